// File: rtl/uart_tx_packet_queue.sv
// Packet FIFO in front of the UART core: launches one packet per UART frame time.
// Optional DROP_COUNT_EN adds a saturating dropped-push counter output.
module uart_tx_packet_queue #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FRAME_CYCLES = 8246
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         ovf_clear,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         empty,
  output logic                         full,
`ifdef DROP_COUNT_EN
  output logic [7:0]                   drop_count,
`endif
  output logic                         overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned TMR_W = $clog2(FRAME_CYCLES);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  pop, push_ok, drop;
`ifdef DROP_COUNT_EN
  logic [7:0]            drop_count_q, drop_count_d;
`endif

  // Launch pacing: pop in IDLE, then hold off for the rest of the frame time
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop         = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = mem_q[rd_ptr_q];
          timer_d     = TMR_W'(FRAME_CYCLES - 1);
          state_d     = HOLD;
        end
      end
      HOLD: begin
        timer_d = timer_q - TMR_W'(1);
        if (timer_q == TMR_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full queue still fits if the head leaves in the same cycle
  always_comb begin
    push_ok  = in_valid && ((level_q < LVL_W'(DEPTH)) || pop);
    drop     = in_valid && !push_ok;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop) level_d = level_q - LVL_W'(1);
    empty_d    = (level_d == '0);
    full_d     = (level_d == LVL_W'(DEPTH));
    overflow_d = overflow_q;
    if (drop)           overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;
`ifdef DROP_COUNT_EN
    drop_count_d = drop_count_q;
    if (drop && ovf_clear)              drop_count_d = 8'd1;
    else if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    else if (ovf_clear && !drop)        drop_count_d = 8'd0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef DROP_COUNT_EN
      drop_count_q <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef DROP_COUNT_EN
      drop_count_q <= drop_count_d;
`endif
    end
  end

  // Storage needs no reset: level gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
`ifdef DROP_COUNT_EN
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_tx_packet_queue.sv
// Directed scoreboard bench for uart_tx_packet_queue with FRAME_CYCLES=20, DEPTH=4.
module tb_uart_tx_packet_queue;

  localparam int unsigned DW = 16;
  localparam int unsigned FC = 20;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          ovf_clear;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    level;
  logic          empty;
  logic          full;
  logic          overflow;
`ifdef DROP_COUNT_EN
  logic [7:0]    drop_count;
`endif

  uart_tx_packet_queue #(.DATA_WIDTH(DW), .DEPTH(4), .FRAME_CYCLES(FC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .ovf_clear  (ovf_clear),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .level      (level),
    .empty      (empty),
    .full       (full),
`ifdef DROP_COUNT_EN
    .drop_count (drop_count),
`endif
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  int          cyc;
  int          t;
  logic        prev_valid;
  logic [DW-1:0] sb[$];
  int          pulse_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; scoreboard every launch strobe
  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      chk("no_back_to_back", 32'(prev_valid), 32'd0);
      pulse_cyc.push_back(cyc);
      chk("launch_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("launch_data", 32'(out_data), 32'(e));
      end
    end
    prev_valid = out_valid;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push1(input logic [DW-1:0] d, input bit accept);
    in_valid = 1'b1;
    in_data  = d;
    if (accept) sb.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    sb.delete();
    pulse_cyc.delete();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_level"},     32'(level),     32'd0);
    chk({tag, "_empty"},     32'(empty),     32'd1);
    chk({tag, "_full"},      32'(full),      32'd0);
    chk({tag, "_overflow"},  32'(overflow),  32'd0);
`ifdef DROP_COUNT_EN
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
`endif
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; prev_valid = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; ovf_clear = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Single push: strobe two cycles later, level back to 0
    t = cyc;
    push1(16'h8800, 1'b1);
    chk("t1_level_after_push", 32'(level), 32'd1);
    chk("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    wait_until(t + 30);

    // Three back-to-back pushes: pulses exactly FC apart, data held between
    do_reset();
    t = cyc;
    push1(16'h8800, 1'b1);
    push1(16'h1234, 1'b1);
    push1(16'h5678, 1'b1);
    while (cyc < t + 50) begin
      tick();
      if (cyc == t + 15) chk("t2_hold0", 32'(out_data), 32'h8800);
      if (cyc == t + 35) chk("t2_hold1", 32'(out_data), 32'h1234);
    end
    chk("t2_npulse", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() == 3) begin
      chk("t2_pulse0", 32'(pulse_cyc[0] - t), 32'd2);
      chk("t2_pulse1", 32'(pulse_cyc[1] - t), 32'd22);
      chk("t2_pulse2", 32'(pulse_cyc[2] - t), 32'd42);
    end
    chk("t2_drained", 32'(sb.size()), 32'd0);
    chk("t2_hold2", 32'(out_data), 32'h5678);

    // Six pushes: one launched, four queued, one dropped
    do_reset();
    t = cyc;
    push1(16'hA000, 1'b1);
    push1(16'hA001, 1'b1);
    push1(16'hA002, 1'b1);
    push1(16'hA003, 1'b1);
    push1(16'hA004, 1'b1);
    push1(16'hA005, 1'b0);
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_overflow", 32'(overflow), 32'd1);
`ifdef DROP_COUNT_EN
    chk("t3_drop_count", 32'(drop_count), 32'd1);
`endif
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);
`ifdef DROP_COUNT_EN
    chk("t3_dc_cleared", 32'(drop_count), 32'd0);
`endif

    // Full queue, push lands on the IDLE pop cycle
    wait_until(t + 21);
    chk("t4_level_before", 32'(level), 32'd4);
    push1(16'hA006, 1'b1);
    chk("t4_pulse", 32'(out_valid), 32'd1);
    chk("t4_level", 32'(level), 32'd4);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_overflow", 32'(overflow), 32'd0);

    // Drop sets overflow; clear coincident with a drop loses to the drop
    push1(16'hA007, 1'b0);
    chk("t5_ovf_set", 32'(overflow), 32'd1);
`ifdef DROP_COUNT_EN
    chk("t5_dc_set", 32'(drop_count), 32'd1);
`endif
    ovf_clear = 1'b1;
    push1(16'hA008, 1'b0);
    ovf_clear = 1'b0;
    chk("t5_drop_wins", 32'(overflow), 32'd1);
`ifdef DROP_COUNT_EN
    chk("t5_dc_one", 32'(drop_count), 32'd1);
`endif
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("t5_ovf_clear", 32'(overflow), 32'd0);
`ifdef DROP_COUNT_EN
    chk("t5_dc_clear", 32'(drop_count), 32'd0);
`endif

    // Asynchronous reset mid-HOLD with three entries queued
    wait_until(t + 45);
    chk("t6_level_before", 32'(level), 32'd3);
    chk("t6_data_before", 32'(out_data), 32'hA002);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
    pulse_cyc.delete();
    t = cyc;
    wait_until(t + 50);
    chk("t6_no_pulse", 32'(pulse_cyc.size()), 32'd0);
    chk("t6_level_after", 32'(level), 32'd0);
    t = cyc;
    push1(16'hABCD, 1'b1);
    tick();
    chk("t6_new_pulse", 32'(out_valid), 32'd1);
    wait_until(t + 25);
    chk("t6_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
